// File: rtl/adc_serial_framer_pkg.sv
// Shared types and helpers for the serial ADC framer.
package adc_serial_framer_pkg;

  // CONV is the only state with bit 0 set, so chip select decodes from one flop.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CONV  = 2'b01,
    S_QUIET = 2'b10
  } state_t;

  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Bit-period counter: serial clock, sample strobe on the rising sclk edge, last-bit strobe.
module adc_sclk_gen #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic last
);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam int BITW = $clog2(NBITS);

  logic [DIVW-1:0] div_cnt;
  logic [BITW-1:0] bit_cnt;
  logic            period_end;

  assign period_end = (div_cnt == DIVW'(CLK_DIV-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
    end else if (period_end) begin
      div_cnt <= '0;
      bit_cnt <= bit_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // rise is true in the cycle whose closing edge takes sclk from 0 to 1
  assign sclk = !(run && (div_cnt < DIVW'(CLK_DIV/2)));
  assign rise = run && (div_cnt == DIVW'(CLK_DIV/2 - 1));
  assign last = run && period_end && (bit_cnt == BITW'(NBITS-1));

endmodule

// File: rtl/adc_serial_framer.sv
// Continuous multi-channel serial ADC reader emitting one stream beat per conversion.
module adc_serial_framer
  import adc_serial_framer_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DW        = 12,
  parameter int LEAD      = 4,
  parameter int CLK_DIV   = 4,
  parameter int QUIET     = 2,
  parameter int FRAME_LEN = 4096
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              enable,
  output logic              adc_sclk,
  output logic              adc_csn,
  input  logic [NCH-1:0]    adc_sdata,
  output logic [NCH*DW-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              overrun
);
  localparam int IW = idx_width(FRAME_LEN);
  localparam int QW = $clog2(QUIET+1);

  state_t            state, state_nxt;
  logic [QW-1:0]     q_cnt;
  logic              run, rise, last, sample_rdy, load, xfer;
  logic [IW-1:0]     idx;
  logic [NCH*DW-1:0] sample;

  assign run     = (state == S_CONV);
  assign adc_csn = ~state[0];

  adc_sclk_gen #(.CLK_DIV(CLK_DIV), .NBITS(LEAD+DW)) u_sclk (
    .clk  (clk),
    .rst  (areset),
    .run  (run),
    .sclk (adc_sclk),
    .rise (rise),
    .last (last)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (enable) state_nxt = S_CONV;
      S_CONV:  if (last) state_nxt = S_QUIET;
      S_QUIET: if (q_cnt == QW'(QUIET-1)) state_nxt = enable ? S_CONV : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)                q_cnt <= '0;
    else if (state == S_QUIET) q_cnt <= q_cnt + 1'b1;
    else                       q_cnt <= '0;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] sr;
    always_ff @(posedge clk or posedge areset) begin
      if (areset)    sr <= '0;
      else if (rise) sr <= {sr[DW-2:0], adc_sdata[i]};
    end
    assign sample[i*DW +: DW] = sr;
  end

  // delays the capture by one cycle so the final shift has settled
  always_ff @(posedge clk or posedge areset) begin
    if (areset) sample_rdy <= 1'b0;
    else        sample_rdy <= last;
  end

  assign xfer = m_tvalid && m_tready;
  assign load = sample_rdy && (!m_tvalid || m_tready);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      overrun  <= 1'b0;
      idx      <= '0;
    end else begin
      if (load) begin
        m_tdata  <= sample;
        m_tlast  <= (idx == IW'(FRAME_LEN-1));
        m_tvalid <= 1'b1;
        idx      <= idx + 1'b1;
      end else if (xfer) begin
        m_tvalid <= 1'b0;
      end
      if (sample_rdy && m_tvalid && !m_tready) overrun <= 1'b1;
      if (state == S_IDLE && !enable) idx <= '0;
    end
  end

endmodule

// File: tb/tb_adc_serial_framer.sv
// Bench for adc_serial_framer: serial ADC model feeding a scoreboard of expected beats.
module tb_adc_serial_framer;
  localparam int NCH = 2, DW = 12, LEAD = 4, CLK_DIV = 4, QUIET = 2, FRAME_LEN = 8;
  localparam int NBITS  = LEAD + DW;
  localparam int PERIOD = NBITS*CLK_DIV + QUIET;

  typedef struct { logic [DW-1:0] ch0; logic [DW-1:0] ch1; logic [NCH*DW-1:0] data; } vec_t;
  typedef struct { logic [NCH*DW-1:0] data; logic last; } exp_t;

  logic clk = 1'b0, areset = 1'b1, enable = 1'b0, m_tready = 1'b1;
  logic [NCH-1:0] adc_sdata = '0;
  logic adc_sclk, adc_csn, m_tvalid, m_tlast, overrun;
  logic [NCH*DW-1:0] m_tdata;

  always #5 clk = ~clk;

  adc_serial_framer #(.NCH(NCH), .DW(DW), .LEAD(LEAD), .CLK_DIV(CLK_DIV),
                      .QUIET(QUIET), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .areset(areset), .enable(enable), .adc_sclk(adc_sclk), .adc_csn(adc_csn),
    .adc_sdata(adc_sdata), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .overrun(overrun));

  int n_checks = 0, n_fail = 0;
  vec_t stim_q[$];
  exp_t sb_q[$];
  logic [DW-1:0] cur0 = '0, cur1 = '0;
  logic [NCH*DW-1:0] cur_exp = '0;
  int bitn = 0, mdl_idx = 0, pops = 0, tl_cnt = 0, cyc = 0, last_rise = 0, gap = 0;
  int rises = 0, last_rises = 0;
  bit push_en = 1'b1, prev_v = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ADC model: new bit on each falling sclk, expected beat queued once all bits are out
  always @(posedge adc_csn or posedge areset) begin
    bitn = 0;
    last_rises = rises;
    rises = 0;
  end

  always @(posedge adc_sclk) if (!adc_csn) rises++;

  always @(negedge adc_sclk) begin
    vec_t v;
    exp_t e;
    if (bitn == 0 && stim_q.size() > 0) begin
      v = stim_q.pop_front();
      cur0 = v.ch0; cur1 = v.ch1; cur_exp = v.data;
    end
    adc_sdata[0] = (bitn < LEAD) ? 1'b0 : cur0[DW-1-(bitn-LEAD)];
    adc_sdata[1] = (bitn < LEAD) ? 1'b0 : cur1[DW-1-(bitn-LEAD)];
    bitn++;
    if (bitn == NBITS && push_en) begin
      e.data = cur_exp;
      e.last = (mdl_idx == FRAME_LEN-1);
      sb_q.push_back(e);
      mdl_idx = (mdl_idx + 1) % FRAME_LEN;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (areset) prev_v = 1'b0;
    else begin
      if (m_tvalid && !prev_v) begin gap = cyc - last_rise; last_rise = cyc; end
      prev_v = m_tvalid;
      if (m_tvalid && m_tready) begin
        if (sb_q.size() == 0) check("unexpected beat", m_tdata, 64'hDEAD);
        else begin
          e = sb_q.pop_front();
          check("beat data", m_tdata, e.data);
          check("beat tlast", m_tlast, e.last);
        end
        pops++;
        if (m_tlast) tl_cnt++;
      end
    end
  end

  task automatic wait_pops(int n, int budget);
    int target = pops + n;
    int k = 0;
    while (pops < target && k < budget) begin @(negedge clk); k++; end
    check("beats delivered", pops >= target, 1);
  endtask

  task automatic wait_taken(int budget);
    int k = 0;
    while (stim_q.size() != 0 && k < budget) begin @(negedge clk); k++; end
    check("stimulus consumed", stim_q.size(), 0);
  endtask

  task automatic wait_bit(int b, int budget);
    int k = 0;
    while (bitn != b && k < budget) begin @(posedge clk); #1; k++; end
    check("reach bit", bitn, b);
  endtask

  task automatic wait_valid(int budget);
    int k = 0;
    while (!m_tvalid && k < budget) begin @(negedge clk); k++; end
    check("valid seen", m_tvalid, 1);
  endtask

  task automatic push_vec(logic [DW-1:0] a, logic [DW-1:0] b);
    vec_t v;
    v.ch0 = a; v.ch1 = b; v.data = {b, a};
    stim_q.push_back(v);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [NCH*DW-1:0] held;
    logic held_last;
    int bad, p0;
    tbl[0] = '{12'h0A5, 12'hF3C, 24'hF3C0A5};
    tbl[1] = '{12'hFFF, 12'h000, 24'h000FFF};
    tbl[2] = '{12'h800, 12'h001, 24'h001800};
    tbl[3] = '{12'h555, 12'hAAA, 24'hAAA555};
    tbl[4] = '{12'h000, 12'h000, 24'h000000};
    tbl[5] = '{12'h0A5, 12'hF3C, 24'hF3C0A5};

    #1;
    check("reset csn", adc_csn, 1);
    check("reset sclk", adc_sclk, 1);
    check("reset tvalid", m_tvalid, 0);
    check("reset tdata", m_tdata, 0);
    check("reset tlast", m_tlast, 0);
    check("reset overrun", overrun, 0);
    check("reset index", dut.idx, 0);
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // fixed patterns, one per conversion, with frame timing checks
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stim_q.push_back(tbl[i]);
      wait_taken(2*PERIOD);
      if (i >= 2) begin
        check("sclk rises per csn window", last_rises, NBITS);
        check("valid interval", gap, PERIOD);
      end
    end
    wait_pops(1, 2*PERIOD);

    // ramp from a fresh frame: tlast on values 7 and 15
    @(posedge clk); #1 enable = 1'b0;
    repeat (2*PERIOD) @(posedge clk);
    #1;
    check("idle csn", adc_csn, 1);
    check("idle index", dut.idx, 0);
    mdl_idx = 0;
    for (int v = 0; v < 16; v++) push_vec(DW'(v), '0);
    tl_cnt = 0;
    enable = 1'b1;
    wait_pops(16, 17*PERIOD + 20);
    check("tlast count over ramp", tl_cnt, 2);

    // ready toggling every cycle
    for (int i = 0; i < 8; i++) push_vec(DW'(12'h100 + i), DW'(12'h200 + i));
    repeat (8*PERIOD) begin @(posedge clk); #1 m_tready = ~m_tready; end
    m_tready = 1'b1;
    check("no overrun while toggling", overrun, 0);

    // held beat transferred on the very edge the next sample loads
    push_vec(12'h3C1, 12'h3C2);
    push_vec(12'h3D1, 12'h3D2);
    repeat (4) @(posedge clk);
    #1 m_tready = 1'b0;
    wait_valid(2*PERIOD);
    p0 = pops;
    repeat (PERIOD-1) @(posedge clk);
    #1 m_tready = 1'b1;
    @(posedge clk); #1;
    check("coincident load valid", m_tvalid, 1);
    check("coincident no overrun", overrun, 0);
    check("held beat transferred", pops, p0 + 1);
    wait_pops(1, 4);

    // enable dropped mid-conversion
    wait_bit(6, 2*PERIOD);
    @(posedge clk); #1 enable = 1'b0;
    wait_pops(1, PERIOD + 10);
    repeat (PERIOD) @(posedge clk);
    #1;
    check("stop csn", adc_csn, 1);
    check("stop sclk", adc_sclk, 1);
    check("stop index", dut.idx, 0);
    check("stop no pending", sb_q.size(), 0);
    mdl_idx = 0;

    // stall for three sample periods
    stim_q.delete();
    push_vec(12'h111, 12'h222);
    push_vec(12'h333, 12'h444);
    push_vec(12'h555, 12'h666);
    push_vec(12'h777, 12'h888);
    m_tready = 1'b0;
    enable = 1'b1;
    wait_valid(2*PERIOD);
    push_en = 1'b0;
    held = m_tdata;
    held_last = m_tlast;
    check("stall first beat", held, 24'h222111);
    check("no overrun before drop", overrun, 0);
    bad = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (m_tdata !== held || m_tvalid !== 1'b1 || m_tlast !== held_last) bad++;
    end
    check("held beat stable", bad, 0);
    check("overrun sticky", overrun, 1);
    check("index after drops", dut.idx, 1);
    @(posedge clk); #1;
    push_en = 1'b1;
    m_tready = 1'b1;
    wait_pops(2, 2*PERIOD);
    check("overrun still set", overrun, 1);

    // reset in the middle of a conversion
    @(posedge clk); #1 m_tready = 1'b0;
    wait_valid(2*PERIOD);
    wait_bit(10, 2*PERIOD);
    @(posedge clk); #1 areset = 1'b1;
    #1;
    check("abort csn", adc_csn, 1);
    check("abort sclk", adc_sclk, 1);
    check("abort tvalid", m_tvalid, 0);
    sb_q.delete();
    stim_q.delete();
    mdl_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check("abort overrun", overrun, 0);
    check("abort tdata", m_tdata, 0);
    push_vec(12'h5A5, 12'h3C3);
    m_tready = 1'b1;
    areset = 1'b0;
    wait_pops(1, 2*PERIOD + 10);

    @(posedge clk); #1 enable = 1'b0;
    repeat (2*PERIOD + 10) @(posedge clk);
    check("no lost beats", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
